button_debounce_array: RTL and testbench
========================================

# button_debounce_array

Parametrised multi-channel push-button conditioner for the Snake front end. Each channel synchronises a raw pin, filters it with a stable-count debouncer, and produces a clean level plus one-cycle press and release strobes. An optional auto-repeat mode re-strobes `O_press` while a button is held, so the direction/control logic can consume pulses instead of polling levels. It sits between the board pins and the game controller, replacing the fixed four-button debouncer.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1); channel order is up, down, right, left for the first four.
- `STABLE_CYCLES`, 8: consecutive samples a new level must hold before it is accepted (≥2).
- `ACTIVE_HIGH`, 1: 1 means pressed = pin high; 0 means pressed = pin low.
- `REPEAT_EN`, 0: 1 enables auto-repeat strobes on `O_press`.
- `REPEAT_DELAY`, 16: cycles from accepted press to the first repeat strobe (≥2).
- `REPEAT_PERIOD`, 8: cycles between later repeat strobes (≥2).
- `I_clk` input 1: the single clock.
- `I_rst` input 1: reset, synchronous, active-high.
- `I_button` input CHANNELS: raw asynchronous pins.
- `O_button` output CHANNELS: debounced level, 1 = pressed, independent of `ACTIVE_HIGH`.
- `O_press` output CHANNELS: one-cycle strobe on accepted press and on each repeat.
- `O_release` output CHANNELS: one-cycle strobe on accepted release.

## Operation
- Synchroniser: two flops per channel. On reset they load the inactive pin level (`~ACTIVE_HIGH`), so no spurious press is generated.
- Normalised sample: `act = sync2` if `ACTIVE_HIGH`, otherwise `~sync2`.
- Stable counter, `$clog2(STABLE_CYCLES)` bits, per channel:
  - If `act == O_button`, the counter clears to 0.
  - Otherwise, if the counter equals `STABLE_CYCLES-1`, toggle `O_button` and clear the counter.
  - Otherwise, increment the counter.
  - The counter never wraps.
- Strobes:
  - `O_press[i]` = 1 for exactly the cycle in which `O_button[i]` rises.
  - `O_release[i]` = 1 for exactly the cycle in which `O_button[i]` falls.
  - All outputs are registered.
- Repeat FSM per channel, active only when `REPEAT_EN=1`:
  - IDLE: on accepted press, load the repeat counter with `REPEAT_DELAY-1` and go to DELAY.
  - DELAY: decrement the counter. At 0, strobe `O_press`, load `REPEAT_PERIOD-1`, go to REPEAT.
  - REPEAT: decrement the counter. At 0, strobe `O_press` and reload `REPEAT_PERIOD-1`.
  - DELAY/REPEAT with accepted release: go to IDLE immediately. Suppress any repeat strobe due in that cycle; only `O_release` fires.
  - The repeat counter width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))`.
- When `REPEAT_EN=0`, the FSM stays in IDLE and synthesises away.
- Channels are fully independent. Simultaneous events on several channels all strobe in the same cycle.
- Glitches: any run of differing samples shorter than `STABLE_CYCLES` leaves `O_button` unchanged and produces no strobe.

## Timing
- Reset: `O_button`, `O_press` and `O_release` are all 0. Counters are 0, the FSM is IDLE, and the synchronisers hold the inactive level. Outputs are valid from the first cycle after `I_rst` deasserts.
- Reset mid-press: the outputs drop to 0. If the pin is still held after reset, a fresh `O_press` follows after the full latency.
- Latency: with a clean step on the pin sampled at edge k, `O_button` and the strobe change at edge k+1+`STABLE_CYCLES` (2 synchroniser flops, then `STABLE_CYCLES` matching samples).
- First repeat strobe: `REPEAT_DELAY` cycles after the press strobe.
- Later repeat strobes: every `REPEAT_PERIOD` cycles.
- Strobes never last more than one cycle. `O_press` and `O_release` are never high together on the same channel.

## Structure
- Shared package `snake_pkg` holds:
  - the repeat FSM state encoding (IDLE, DELAY, REPEAT; 2 bits);
  - the channel index constants `BTN_UP=0`, `BTN_DOWN=1`, `BTN_RIGHT=2`, `BTN_LEFT=3`.
- Sub-module `debounce_channel`: synchroniser, stable counter, strobe logic and repeat FSM for one channel. The top level instantiates it `CHANNELS` times in a generate loop and only concatenates outputs.

## Test plan
- Reset with all pins held active → all outputs 0 during reset. After deassert with `STABLE_CYCLES=8`, `O_press[0]` pulses once, 9 cycles after the first sampling edge.
- Bounce: pin 1 toggles with runs of 3, 5 and 7 cycles, then holds for 20 → exactly one `O_press[1]` and `O_button[1]`=1 8 samples into the stable run. A run of 7 alone produces nothing.
- Release: channel 2 held, then released cleanly → a single `O_release[2]` and `O_button[2]` falls in the same cycle; `O_press[2]` stays 0.
- Auto-repeat with `REPEAT_EN=1`, `DELAY=16`, `PERIOD=8`, channel 3 held 60 cycles past acceptance → `O_press[3]` strobes at offsets 0, 16, 24, 32, 40, 48, 56.
  - Release timed in the cycle a repeat is due → only `O_release` fires.
- Simultaneous: all 4 pins press on the same edge → all 4 `O_press` bits strobe in the same cycle.
- `ACTIVE_HIGH=0`, pin driven low → `O_button` rises to 1 with the same latency as the active-high case.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the Snake front end: repeat FSM encoding and button channel indices.
package snake_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_RIGHT = 2;
   localparam int BTN_LEFT  = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_debounce_array_if.sv
// Pin and strobe bundle between the board-side buttons and the debounce array.
interface button_debounce_array_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] I_button;
   logic [CHANNELS-1:0] O_button;
   logic [CHANNELS-1:0] O_press;
   logic [CHANNELS-1:0] O_release;

   modport master (output I_button, input O_button, O_press, O_release);
   modport slave  (input I_button, output O_button, O_press, O_release);
endinterface

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stable-count debouncer, press/release
// strobes and an optional auto-repeat FSM that re-strobes press while held.
module debounce_channel
   import snake_pkg::*;
#(
   parameter int STABLE_CYCLES = 8,
   parameter int ACTIVE_HIGH   = 1,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 16,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic I_clk,
   input  logic I_rst,
   input  logic I_pin,
   output logic O_button,
   output logic O_press,
   output logic O_release
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [CW-1:0] CNT_MAX     = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);
   localparam logic          PIN_IDLE    = (ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

   logic          sync1_q, sync2_q;
   logic          act;
   logic          btn_d, btn_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic          rise_d, fall_d;
   logic          release_q, press_q;
   rpt_state_e    rpt_state_q;
   logic [RW-1:0] rcnt_q;

   always_comb begin
      act    = (ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;
      btn_d  = btn_q;
      cnt_d  = cnt_q;
      if (act == btn_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         btn_d = ~btn_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      rise_d = btn_d & ~btn_q;
      fall_d = ~btn_d & btn_q;
   end

   // Synchronisers reset to the inactive pin level so reset never looks like a press.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         sync1_q   <= PIN_IDLE;
         sync2_q   <= PIN_IDLE;
         btn_q     <= 1'b0;
         cnt_q     <= '0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= I_pin;
         sync2_q   <= sync1_q;
         btn_q     <= btn_d;
         cnt_q     <= cnt_d;
         release_q <= fall_d;
      end
   end

   // A release always wins over a repeat strobe due in the same cycle.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         rpt_state_q <= RPT_IDLE;
         rcnt_q      <= '0;
         press_q     <= 1'b0;
      end else begin
         press_q <= rise_d;
         if (REPEAT_EN != 0) begin
            unique case (rpt_state_q)
               RPT_IDLE: begin
                  if (rise_d) begin
                     rpt_state_q <= RPT_DELAY;
                     rcnt_q      <= DELAY_LOAD;
                  end
               end
               RPT_DELAY, RPT_REPEAT: begin
                  if (fall_d) begin
                     rpt_state_q <= RPT_IDLE;
                  end else if (rcnt_q == '0) begin
                     press_q     <= 1'b1;
                     rcnt_q      <= PERIOD_LOAD;
                     rpt_state_q <= RPT_REPEAT;
                  end else begin
                     rcnt_q <= rcnt_q - 1'b1;
                  end
               end
               default: rpt_state_q <= RPT_IDLE;
            endcase
         end
      end
   end

   assign O_button  = btn_q;
   assign O_press   = press_q;
   assign O_release = release_q;

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel push-button conditioner: one independent debounce_channel per pin.
module button_debounce_array
   import snake_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int STABLE_CYCLES = 8,
   parameter int ACTIVE_HIGH   = 1,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 16,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic                   I_clk,
   input  logic                   I_rst,
   button_debounce_array_if.slave btn_if
);

   logic [CHANNELS-1:0] btn_w, press_w, release_w;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES(STABLE_CYCLES),
         .ACTIVE_HIGH  (ACTIVE_HIGH),
         .REPEAT_EN    (REPEAT_EN),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
         .I_clk    (I_clk),
         .I_rst    (I_rst),
         .I_pin    (btn_if.I_button[g]),
         .O_button (btn_w[g]),
         .O_press  (press_w[g]),
         .O_release(release_w[g])
      );
   end

   assign btn_if.O_button  = btn_w;
   assign btn_if.O_press   = press_w;
   assign btn_if.O_release = release_w;

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array: default, auto-repeat and active-low instances.
module tb_button_debounce_array;
   import snake_pkg::*;

   localparam int CH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   button_debounce_array_if #(.CHANNELS(CH)) bus_a ();
   button_debounce_array_if #(.CHANNELS(CH)) bus_r ();
   button_debounce_array_if #(.CHANNELS(CH)) bus_l ();

   button_debounce_array #(.CHANNELS(CH)) u_dut (
      .I_clk(clk), .I_rst(rst), .btn_if(bus_a)
   );
   button_debounce_array #(.CHANNELS(CH), .REPEAT_EN(1), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)) u_rep (
      .I_clk(clk), .I_rst(rst), .btn_if(bus_r)
   );
   button_debounce_array #(.CHANNELS(CH), .ACTIVE_HIGH(0)) u_low (
      .I_clk(clk), .I_rst(rst), .btn_if(bus_l)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   initial begin
      int np, nr, at, ra, btn_at;
      logic [CH-1:0] p9, p10, p11, r10, rp10;
      int rep_q[$];
      int exp_rep[7] = '{10, 26, 34, 42, 50, 58, 66};

      bus_a.I_button = '1;
      bus_r.I_button = '0;
      bus_l.I_button = '1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_eq("rst_btn",     32'(bus_a.O_button),  0);
      chk_eq("rst_press",   32'(bus_a.O_press),   0);
      chk_eq("rst_release", 32'(bus_a.O_release), 0);
      chk_eq("rst_low_btn", 32'(bus_l.O_button),  0);

      // pins held active through reset: press lands 9 cycles after first sampling edge
      rst = 1'b0;
      np = 0; at = 0; p10 = '0;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (bus_a.O_press[BTN_UP]) begin np++; at = j; end
         if (j == 10) p10 = bus_a.O_press;
      end
      chk_eq("rst_press_cnt", np, 1);
      chk_eq("rst_press_at",  at, 10);
      chk_eq("rst_press_all", 32'(p10), 32'hF);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_eq("midrst_btn", 32'(bus_a.O_button), 0);
      rst = 1'b0;
      np = 0; at = 0;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (bus_a.O_press[BTN_UP]) begin np++; at = j; end
      end
      chk_eq("midrst_press_cnt", np, 1);
      chk_eq("midrst_press_at",  at, 10);

      bus_a.I_button = 4'b0100;
      repeat (14) @(negedge clk);
      chk_eq("hold2_btn", 32'(bus_a.O_button), 32'b0100);

      bus_a.I_button = '0;
      np = 0; nr = 0; ra = 0; btn_at = 1;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (bus_a.O_press[BTN_RIGHT]) np++;
         if (bus_a.O_release[BTN_RIGHT]) begin nr++; ra = j; btn_at = 32'(bus_a.O_button[BTN_RIGHT]); end
      end
      chk_eq("rel2_cnt",   nr, 1);
      chk_eq("rel2_at",    ra, 10);
      chk_eq("rel2_press", np, 0);
      chk_eq("rel2_btn",   btn_at, 0);

      np = 0;
      for (int j = 1; j <= 20; j++) begin
         bus_a.I_button[BTN_DOWN] = (j <= 7);
         @(negedge clk);
         if (bus_a.O_press[BTN_DOWN]) np++;
      end
      chk_eq("run7_press", np, 0);
      chk_eq("run7_btn",   32'(bus_a.O_button[BTN_DOWN]), 0);

      // runs of 3 high, 5 low, 7 high, 3 low, then stable high from edge 19
      np = 0; nr = 0; at = 0;
      for (int j = 1; j <= 40; j++) begin
         bus_a.I_button[BTN_DOWN] = (j <= 3) || (j >= 9 && j <= 15) || (j >= 19);
         @(negedge clk);
         if (bus_a.O_press[BTN_DOWN]) begin np++; at = j; end
         if (bus_a.O_release[BTN_DOWN]) nr++;
      end
      chk_eq("bounce_press_cnt", np, 1);
      chk_eq("bounce_press_at",  at, 28);
      chk_eq("bounce_btn",       32'(bus_a.O_button[BTN_DOWN]), 1);
      chk_eq("bounce_release",   nr, 0);

      bus_a.I_button = '0;
      repeat (14) @(negedge clk);

      bus_a.I_button = '1;
      p9 = '1; p10 = '0; p11 = '1;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (j == 9)  p9  = bus_a.O_press;
         if (j == 10) p10 = bus_a.O_press;
         if (j == 11) p11 = bus_a.O_press;
      end
      chk_eq("sim_press_9",  32'(p9),  0);
      chk_eq("sim_press_10", 32'(p10), 32'hF);
      chk_eq("sim_press_11", 32'(p11), 0);

      bus_a.I_button = '0;
      r10 = '0; rp10 = '1;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (j == 10) begin r10 = bus_a.O_release; rp10 = bus_a.O_press; end
      end
      chk_eq("sim_release_10",  32'(r10),  32'hF);
      chk_eq("sim_rel_press_10", 32'(rp10), 0);

      // auto-repeat: release accepted exactly when the repeat at edge 74 is due
      nr = 0; ra = 0;
      for (int j = 1; j <= 85; j++) begin
         bus_r.I_button[BTN_LEFT] = (j <= 64);
         @(negedge clk);
         if (bus_r.O_press[BTN_LEFT]) rep_q.push_back(j);
         if (bus_r.O_release[BTN_LEFT]) begin nr++; ra = j; end
      end
      chk_eq("rep_cnt", rep_q.size(), 7);
      for (int i = 0; i < 7; i++)
         chk_eq($sformatf("rep_at%0d", i), (i < rep_q.size()) ? rep_q[i] : -1, exp_rep[i]);
      chk_eq("rep_rel_cnt", nr, 1);
      chk_eq("rep_rel_at",  ra, 74);

      np = 0; at = 0;
      bus_l.I_button[BTN_UP] = 1'b0;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (bus_l.O_press[BTN_UP]) begin np++; at = j; end
      end
      chk_eq("low_press_cnt", np, 1);
      chk_eq("low_press_at",  at, 10);
      chk_eq("low_btn",       32'(bus_l.O_button), 32'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
